uart_tx_buffered: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 68 ++++++
 rtl/uart_tx_buffered.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity encodings,
// transmit FSM states and the baud divider calculation.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Nearest-integer clocks per bit; every bit then lasts exactly this many clocks.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data, a level count
// and full/empty flags. Pointers wrap naturally because DEPTH is a power of two.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             pop_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_sync_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (level_q == FULL_LVL);
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a write FIFO; frame format (parity, stop bits) is
// captured per word when it is popped, so format changes apply from the next frame.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_BITS-1:0]              in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        parity_mode,
  input  logic                              two_stop,
  output logic                              txd,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = (CPB < 2) ? 1 : $clog2(CPB);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  generate
    if (CPB < 2) begin : g_bad_baud
      $error("uart_tx_buffered: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("uart_tx_buffered: DATA_BITS must be in 5..9");
    end
  endgenerate

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;

  tx_state_e            state_q;
  logic [CNT_W-1:0]     baud_cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           par_mode_q;
  logic                 par_bit_q;
  logic                 two_stop_q;
  logic                 txd_q;

  logic                 bit_end;
  logic                 last_stop;
  logic                 par_bit_d;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (in_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign bit_end   = (baud_cnt_q == LAST_CNT);
  assign last_stop = ~two_stop_q | stop_cnt_q;

  // A new frame starts from IDLE, or back-to-back on the last clock of the final stop bit.
  assign fifo_pop = ~fifo_empty &
                    ((state_q == ST_IDLE) |
                     ((state_q == ST_STOP) & bit_end & last_stop));

  always_comb begin
    par_bit_d = 1'b0;
    case (parity_mode)
      PAR_EVEN: par_bit_d = ^fifo_rd_data;
      PAR_ODD:  par_bit_d = ~^fifo_rd_data;
      PAR_MARK: par_bit_d = 1'b1;
      default:  par_bit_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_mode_q <= PAR_NONE;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      txd_q      <= 1'b1;
    end else if (fifo_pop) begin
      state_q    <= ST_START;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= fifo_rd_data;
      par_mode_q <= parity_mode;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop;
      txd_q      <= 1'b0;
    end else begin
      if (state_q == ST_IDLE || bit_end) begin
        baud_cnt_q <= '0;
      end else begin
        baud_cnt_q <= baud_cnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          txd_q <= 1'b1;
        end
        ST_START: begin
          if (bit_end) begin
            state_q <= ST_DATA;
            txd_q   <= shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == LAST_IDX) begin
              if (par_mode_q != PAR_NONE) begin
                state_q <= ST_PARITY;
                txd_q   <= par_bit_q;
              end else begin
                state_q <= ST_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              // Bit 1 of the current register is the next bit on the line.
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_q <= ST_STOP;
            txd_q   <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              stop_cnt_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              txd_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign txd  = txd_q;
  assign busy = (state_q != ST_IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 12 clocks per bit: frame vectors,
// back-to-back frames, FIFO fill, mid-frame format change and mid-frame reset.
module tb_uart_tx_buffered;

  localparam int CPB = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  pm;
    logic        ts;
    logic [63:0] bits;   // line bits, first transmitted in bit 0
    int          nbits;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] burst_w [6];
  int         accepted;
  logic       burst_take;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLK_FREQ   (12000000),
    .BAUD       (1000000),
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .txd         (txd),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Samples txd on every falling edge for nbits bit times; busy must stay high.
  task automatic check_wave(input string name, input logic [63:0] bits, input int nbits);
    int   first_bad = -1;
    int   busy_bad  = -1;
    logic got_bit   = 1'b0;
    logic want_bit;
    for (int k = 0; k < nbits * CPB; k++) begin
      @(negedge clk);
      want_bit = bits[k / CPB];
      if (txd !== want_bit && first_bad < 0) begin
        first_bad = k;
        got_bit   = txd;
      end
      if (busy !== 1'b1 && busy_bad < 0) busy_bad = k;
    end
    checks++;
    if (first_bad >= 0) begin
      fails++;
      $display("FAIL %s: clock %0d (bit %0d) txd=%b, expected %b",
               name, first_bad, first_bad / CPB, got_bit, bits[first_bad / CPB]);
    end
    checks++;
    if (busy_bad >= 0) begin
      fails++;
      $display("FAIL %s_busy: busy low at clock %0d, expected high", name, busy_bad);
    end
  endtask

  task automatic push_word(input logic [7:0] d, input logic [1:0] pm, input logic ts);
    in_data     = d;
    parity_mode = pm;
    two_stop    = ts;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 2'b00, 1'b0, 64'({1'b1, 8'hA5, 1'b0}), 10};
    vecs[1] = '{8'hA5, 2'b01, 1'b0, 64'({1'b1, 1'b0, 8'hA5, 1'b0}), 11};
    vecs[2] = '{8'hA5, 2'b10, 1'b0, 64'({1'b1, 1'b1, 8'hA5, 1'b0}), 11};
    vecs[3] = '{8'h07, 2'b10, 1'b0, 64'({1'b1, 1'b0, 8'h07, 1'b0}), 11};
    vecs[4] = '{8'h3C, 2'b11, 1'b0, 64'({1'b1, 1'b1, 8'h3C, 1'b0}), 11};
    vecs[5] = '{8'h00, 2'b00, 1'b1, 64'({2'b11, 8'h00, 1'b0}), 11};
    vecs[6] = '{8'h81, 2'b01, 1'b1, 64'({2'b11, 1'b0, 8'h81, 1'b0}), 12};
    vecs[7] = '{8'h80, 2'b01, 1'b0, 64'({1'b1, 1'b1, 8'h80, 1'b0}), 11};
    burst_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    rst         = 1'b1;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_txd", 64'(txd), 64'(1'b1));
    check("reset_busy", 64'(busy), 64'(1'b0));
    check("reset_in_ready", 64'(in_ready), 64'(1'b1));
    check("reset_level", 64'(fifo_level), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frames from idle; the format inputs are scrambled once the frame has started.
    for (int i = 0; i < 8; i++) begin
      push_word(vecs[i].data, vecs[i].pm, vecs[i].ts);
      @(negedge clk);
      check($sformatf("v%0d_lead_txd", i), 64'(txd), 64'(1'b1));
      check($sformatf("v%0d_lead_level", i), 64'(fifo_level), 64'(1));
      fork
        check_wave($sformatf("v%0d_frame", i), vecs[i].bits, vecs[i].nbits);
        begin
          @(posedge clk);
          #1;
          parity_mode = ~vecs[i].pm;
          two_stop    = ~vecs[i].ts;
        end
      join
      @(negedge clk);
      check($sformatf("v%0d_idle_busy", i), 64'(busy), 64'(1'b0));
      check($sformatf("v%0d_idle_txd", i), 64'(txd), 64'(1'b1));
      $display("vector %0d: data=%02h parity_mode=%b two_stop=%b frame_bits=%0d",
               i, vecs[i].data, vecs[i].pm, vecs[i].ts, vecs[i].nbits);
      repeat (3) @(negedge clk);
    end

    // Back-to-back frames with two stop bits and no gap between them.
    in_data     = 8'h00;
    parity_mode = 2'b00;
    two_stop    = 1'b1;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_data = 8'hFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_level_push_pop", 64'(fifo_level), 64'(1));
    check_wave("b2b_two_stop", 64'({2'b11, 8'hFF, 1'b0, 2'b11, 8'h00, 1'b0}), 22);
    @(negedge clk);
    check("b2b_idle_busy", 64'(busy), 64'(1'b0));
    $display("sequence b2b: 00 then FF, two stop bits, 22 bit times");
    two_stop = 1'b0;
    repeat (3) @(negedge clk);

    // in_valid held high with six words: one in flight plus four buffered.
    in_data     = burst_w[0];
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    accepted = 1;
    in_data  = burst_w[1];
    fork
      begin
        @(posedge clk);
        check_wave("burst_frames",
                   64'({1'b1, 8'h55, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0,
                        1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}), 50);
      end
      begin
        for (int c = 0; c < 40; c++) begin
          burst_take = in_ready & in_valid;
          @(posedge clk);
          #1;
          if (burst_take) begin
            accepted++;
            if (accepted < 6) in_data = burst_w[accepted];
            else in_valid = 1'b0;
          end
        end
        check("burst_level_full", 64'(fifo_level), 64'(4));
        check("burst_in_ready_low", 64'(in_ready), 64'(1'b0));
        in_valid = 1'b0;
      end
    join
    check("burst_accepted", 64'(accepted), 64'(5));
    @(negedge clk);
    check("burst_idle_busy", 64'(busy), 64'(1'b0));
    check("burst_idle_level", 64'(fifo_level), 64'(0));
    $display("sequence burst: %0d words accepted of 6 offered", accepted);
    repeat (3) @(negedge clk);

    // Parity switched on during DATA of the first frame only affects the second.
    in_data     = 8'h5A;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_data = 8'hC3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fork
      check_wave("parity_toggle", 64'({1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 8'h5A, 1'b0}), 21);
      begin
        repeat (30) @(posedge clk);
        #1;
        parity_mode = 2'b01;
      end
    join
    @(negedge clk);
    check("parity_toggle_idle", 64'(busy), 64'(1'b0));
    $display("sequence parity_toggle: 5A without parity, C3 with even parity");
    parity_mode = 2'b00;
    repeat (3) @(negedge clk);

    // Reset while a frame is in DATA and three words are queued.
    in_valid = 1'b1;
    for (int w = 0; w < 4; w++) begin
      in_data = 8'(w == 0 ? 8'h00 : 8'hF0 + w);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("rst_seq_queued", 64'(fifo_level), 64'(3));
    repeat (28) @(posedge clk);
    #1;
    check("rst_seq_txd_mid_data", 64'(txd), 64'(1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_seq_txd", 64'(txd), 64'(1'b1));
    check("rst_seq_level", 64'(fifo_level), 64'(0));
    check("rst_seq_busy", 64'(busy), 64'(1'b0));
    check("rst_seq_in_ready", 64'(in_ready), 64'(1'b1));
    begin
      int quiet_bad = -1;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if ((txd !== 1'b1 || busy !== 1'b0) && quiet_bad < 0) quiet_bad = k;
      end
      check("rst_seq_no_more_frames", 64'(quiet_bad), 64'(-1));
    end
    $display("sequence reset: frame aborted with 3 words queued");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
